hb_dec_sched: RTL and testbench

Scheduler for the cascaded half-band decimation chain on the receive path. It replaces per-stage divided clocks with single-clock enable strobes. It generates each stage's input-sample enable and polyphase branch select (E0/E1), plus a flush pulse for the filter delay lines. It also produces a decimated output-valid strobe, which is masked during a configurable settle period after start.

---
 rtl/hb_dec_sched.sv | 138 +++++++++++++
 tb/tb_hb_dec_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hb_dec_sched.sv
`default_nettype none
// ============================================================================
// Module      : hb_dec_sched
// Description : Single-clock scheduler for a cascade of half-band decimate-
//               by-2 stages. Produces per-stage sample enables, polyphase
//               branch selects, a delay-line flush pulse and a decimated
//               output-valid strobe that is masked for a settle period.
// Revision    : 1.0 - initial release
// ============================================================================
module hb_dec_sched #(
    parameter int N_STAGES = 3,
    parameter int CFG_W    = $clog2(N_STAGES + 1),
    parameter int SETTLE   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [CFG_W-1:0]    cfg_stages,
    input  logic                in_valid,
    output logic [N_STAGES-1:0] stage_en,
    output logic [N_STAGES-1:0] phase,
    output logic                flush,
    output logic                out_valid,
    output logic                busy,
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Last candidate index that is still swallowed while settling.
    localparam logic [7:0] c_settle_last = 8'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t              r_state;
    logic [N_STAGES-1:0] r_cnt;
    logic [7:0]          r_settle;
    logic [CFG_W-1:0]    r_m;

    // w_all[k]: the k low bits of the phase counter are all ones.
    logic [N_STAGES:0]   w_all;
    logic [N_STAGES-1:0] w_en;
    logic [N_STAGES-1:0] w_ph;
    logic                w_cand;
    logic                w_cfg_ok;
    logic                w_count;

    genvar k;
    generate
        for (k = 0; k <= N_STAGES; k++) begin : g_all_ones
            localparam logic [N_STAGES-1:0] c_mask = N_STAGES'((1 << k) - 1);
            assign w_all[k] = &(r_cnt | ~c_mask);
        end
    endgenerate

    assign w_cfg_ok = (int'(cfg_stages) <= N_STAGES);
    assign w_count  = (r_state != ST_IDLE) && in_valid;

    // Per-stage enables/branches for the active stages and the decimated candidate.
    always_comb begin
        w_en   = '0;
        w_ph   = '0;
        w_cand = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (i < int'(r_m)) begin
                w_en[i] = w_all[i];
                w_ph[i] = w_all[i] & r_cnt[i];
            end
        end
        for (int j = 0; j <= N_STAGES; j++) begin
            if (int'(r_m) == j) begin
                w_cand = w_all[j];
            end
        end
    end

    // Control FSM with registered strobes; stop has priority over start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_settle  <= '0;
            r_m       <= '0;
            stage_en  <= '0;
            phase     <= '0;
            flush     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            stage_en  <= '0;
            phase     <= '0;
            flush     <= 1'b0;
            out_valid <= 1'b0;
            if (stop) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                busy    <= 1'b0;
            end else if (start) begin
                if (w_cfg_ok) begin
                    r_m      <= cfg_stages;
                    r_cnt    <= '0;
                    r_settle <= '0;
                    flush    <= 1'b1;
                    cfg_err  <= 1'b0;
                    busy     <= 1'b1;
                    r_state  <= (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                end else begin
                    // A rejected configuration abandons any chain in progress.
                    cfg_err <= 1'b1;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            end else if (w_count) begin
                stage_en <= w_en;
                phase    <= w_ph;
                r_cnt    <= r_cnt + 1'b1;
                if (r_state == ST_SETTLE) begin
                    if (w_cand) begin
                        if (r_settle == c_settle_last) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_settle <= r_settle + 8'd1;
                        end
                    end
                end else begin
                    out_valid <= w_cand;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hb_dec_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hb_dec_sched
// Description : Scoreboard bench for hb_dec_sched. Two instances (settle 0
//               and settle 3) share clock and reset; expected strobe events
//               are queued by the stimulus and consumed by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hb_dec_sched;

    typedef struct {
        int         t;
        logic [2:0] en;
        logic [2:0] ph;
        logic       ov;
        logic       fl;
    } ev_t;

    logic clk;
    logic rst_n;

    logic       st_a, sp_a, iv_a, fl_a, ov_a, bz_a, er_a;
    logic [2:0] cfg_a, en_a, ph_a;
    logic       st_b, sp_b, iv_b, fl_b, ov_b, bz_b, er_b;
    logic [2:0] cfg_b, en_b, ph_b;

    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  rd_a   = 0;
    int  rd_b   = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    // Hand-derived stage enable / branch patterns over one counter period.
    logic [2:0] tab_en_m3[8] = '{3'b001, 3'b011, 3'b001, 3'b111, 3'b001, 3'b011, 3'b001, 3'b111};
    logic [2:0] tab_ph_m3[8] = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b000, 3'b001, 3'b000, 3'b111};
    logic [2:0] tab_en_m2[4] = '{3'b001, 3'b011, 3'b001, 3'b011};
    logic [2:0] tab_ph_m2[4] = '{3'b000, 3'b001, 3'b000, 3'b011};
    logic       tab_iv_m0[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    hb_dec_sched #(.N_STAGES(3), .CFG_W(3), .SETTLE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .stop(sp_a), .cfg_stages(cfg_a),
        .in_valid(iv_a), .stage_en(en_a), .phase(ph_a), .flush(fl_a),
        .out_valid(ov_a), .busy(bz_a), .cfg_err(er_a)
    );

    hb_dec_sched #(.N_STAGES(3), .CFG_W(3), .SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .stop(sp_b), .cfg_stages(cfg_b),
        .in_valid(iv_b), .stage_en(en_b), .phase(ph_b), .flush(fl_b),
        .out_valid(ov_b), .busy(bz_b), .cfg_err(er_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic cmp_ev(input string name, input ev_t e, input logic [2:0] en,
                          input logic [2:0] ph, input logic ov, input logic fl, input logic bz);
        n_chk++;
        if (e.t == cyc && e.en == en && e.ph == ph && e.ov == ov && e.fl == fl && bz == 1'b1)
            n_pass++;
        else
            $display("FAIL %s: got t=%0d en=%b ph=%b ov=%b fl=%b busy=%b expected t=%0d en=%b ph=%b ov=%b fl=%b busy=1",
                     name, cyc, en, ph, ov, fl, bz, e.t, e.en, e.ph, e.ov, e.fl);
    endtask

    // Monitor: any strobe activity consumes the next expected event.
    always @(negedge clk) begin
        if (|{en_a, ph_a, fl_a, ov_a}) begin
            if (rd_a >= q_a.size()) begin
                n_chk++;
                $display("FAIL ev_a: unexpected strobe at t=%0d en=%b ph=%b ov=%b fl=%b", cyc, en_a, ph_a, ov_a, fl_a);
            end else begin
                cmp_ev("ev_a", q_a[rd_a], en_a, ph_a, ov_a, fl_a, bz_a);
                rd_a++;
            end
        end
        if (|{en_b, ph_b, fl_b, ov_b}) begin
            if (rd_b >= q_b.size()) begin
                n_chk++;
                $display("FAIL ev_b: unexpected strobe at t=%0d en=%b ph=%b ov=%b fl=%b", cyc, en_b, ph_b, ov_b, fl_b);
            end else begin
                cmp_ev("ev_b", q_b[rd_b], en_b, ph_b, ov_b, fl_b, bz_b);
                rd_b++;
            end
        end
    end

    // Expect an event from the clock edge that follows the current drive.
    task automatic push(input int d, input logic [2:0] en, input logic [2:0] ph, input logic ov, input logic fl);
        ev_t e;
        e.t  = cyc + 1;
        e.en = en;
        e.ph = ph;
        e.ov = ov;
        e.fl = fl;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic step(input int d, input logic st, input logic sp, input logic [2:0] cfg, input logic iv);
        st_a = 1'b0; sp_a = 1'b0; cfg_a = 3'd0; iv_a = 1'b0;
        st_b = 1'b0; sp_b = 1'b0; cfg_b = 3'd0; iv_b = 1'b0;
        if (d == 0) begin
            st_a = st; sp_a = sp; cfg_a = cfg; iv_a = iv;
        end else begin
            st_b = st; sp_b = sp; cfg_b = cfg; iv_b = iv;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        st_a = 1'b0; sp_a = 1'b0; cfg_a = 3'd0; iv_a = 1'b0;
        st_b = 1'b0; sp_b = 1'b0; cfg_b = 3'd0; iv_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", int'({en_a, ph_a, fl_a, ov_a, bz_a, er_a}), 0);
        chk("reset_outputs_b", int'({en_b, ph_b, fl_b, ov_b, bz_b, er_b}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // M=3, no settle, back-to-back samples; in_valid with start is not counted.
        push(0, 3'b000, 3'b000, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 3'd3, 1'b1);
        for (int s = 1; s <= 24; s++) begin
            push(0, tab_en_m3[(s - 1) % 8], tab_ph_m3[(s - 1) % 8], ((s % 8) == 0), 1'b0);
            step(0, 1'b0, 1'b0, 3'd0, 1'b1);
        end
        chk("busy_in_run", int'(bz_a), 1);

        // Asynchronous reset mid-run clears outputs without waiting for a clock.
        iv_a = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({en_a, ph_a, fl_a, ov_a, bz_a, er_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(0, 1'b0, 1'b0, 3'd0, 1'b1);
        chk("idle_after_reset", int'(bz_a), 0);

        // Out-of-range configuration is rejected without flush.
        step(0, 1'b1, 1'b0, 3'd4, 1'b0);
        chk("cfg_err_set", int'(er_a), 1);
        chk("cfg_err_not_busy", int'(bz_a), 0);

        // Bypass: out_valid mirrors in_valid, no stage enables.
        push(0, 3'b000, 3'b000, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("cfg_err_cleared", int'(er_a), 0);
        for (int i = 0; i < 6; i++) begin
            if (tab_iv_m0[i]) push(0, 3'b000, 3'b000, 1'b1, 1'b0);
            step(0, 1'b0, 1'b0, 3'd0, tab_iv_m0[i]);
        end
        step(0, 1'b0, 1'b1, 3'd0, 1'b0);
        chk("busy_after_stop", int'(bz_a), 0);

        // M=2, settle of 3 candidates, one sample every third cycle.
        push(1, 3'b000, 3'b000, 1'b0, 1'b1);
        step(1, 1'b1, 1'b0, 3'd2, 1'b0);
        for (int s = 1; s <= 24; s++) begin
            push(1, tab_en_m2[(s - 1) % 4], tab_ph_m2[(s - 1) % 4], ((s % 4) == 0) && (s >= 16), 1'b0);
            step(1, 1'b0, 1'b0, 3'd0, 1'b1);
            step(1, 1'b0, 1'b0, 3'd0, 1'b0);
            step(1, 1'b0, 1'b0, 3'd0, 1'b0);
        end

        // Restart while running: flush, counter restarts, settle applies again.
        push(1, 3'b000, 3'b000, 1'b0, 1'b1);
        step(1, 1'b1, 1'b0, 3'd2, 1'b1);
        for (int s = 1; s <= 16; s++) begin
            push(1, tab_en_m2[(s - 1) % 4], tab_ph_m2[(s - 1) % 4], (s == 16), 1'b0);
            step(1, 1'b0, 1'b0, 3'd0, 1'b1);
        end

        // Start and stop together: stop wins, no flush, no further strobes.
        step(1, 1'b1, 1'b1, 3'd2, 1'b0);
        chk("start_stop_idle", int'(bz_b), 0);
        repeat (3) step(1, 1'b0, 1'b0, 3'd0, 1'b1);

        step(0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("pending_events_a", rd_a, q_a.size());
        chk("pending_events_b", rd_b, q_b.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
